// File: rtl/uart_rx_ctrl.sv
// Purpose : UART receive controller; gates RX bytes into a show-ahead FIFO
//           with sticky overrun / error / idle-timeout status for the host.
// Latency : a byte pulsed at edge N is visible on m_data/m_valid after edge N.
// Backpressure: host stalls via m_ready; when the FIFO is full and not popping,
//           incoming bytes are dropped and overrun is flagged (RX cannot stall).
//
// Ports (uart_rx_ctrl):
//   clk, reset (async, active-low)
//   rx_enable, rx_data[7:0], rx_data_valid, rx_parity_error, rx_frame_error
//   m_data[7:0], m_perr, m_ferr, m_valid, m_ready      host valid/ready port
//   fifo_level[$clog2(DEPTH):0]                        entries held, 0..DEPTH
//   overrun, err_seen, timeout_irq, clr_status         sticky status + clear

// Generic show-ahead FIFO. Caller guarantees push only when !full or popping,
// and pop only when !empty. rdat reads 0 while empty.
module uart_rx_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdat,
  output logic [W-1:0]             rdat,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign rdat  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdat;
  end

  // DEPTH is a power of two, so pointer wrap is natural overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end
endmodule

module uart_rx_ctrl #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 41667
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_enable,
  input  logic [7:0]             rx_data,
  input  logic                   rx_data_valid,
  input  logic                   rx_parity_error,
  input  logic                   rx_frame_error,
  output logic [7:0]             m_data,
  output logic                   m_perr,
  output logic                   m_ferr,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   overrun,
  output logic                   err_seen,
  output logic                   timeout_irq,
  input  logic                   clr_status
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DRAIN} state_t;

  state_t          state, state_nxt;
  logic            full, empty;
  logic            push_en, pop_en;
  logic [LW-1:0]   level_nxt;
  logic [9:0]      head_dat;
  logic [CW-1:0]   idle_cnt;
  logic            idle_clr, to_hit;
  logic            ovr_set, err_set;

  assign pop_en  = m_valid & m_ready;
  // A full FIFO still accepts a byte when the head leaves the same cycle.
  assign push_en = rx_data_valid & (state == ST_RUN) & (!full | pop_en);
  assign ovr_set = rx_data_valid &
                   (((state == ST_RUN) & full & !pop_en) | (state == ST_DRAIN));
  assign err_set = push_en & (rx_parity_error | rx_frame_error);

  uart_rx_fifo #(.W(10), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_en),
    .pop   (pop_en),
    .wdat  ({rx_frame_error, rx_parity_error, rx_data}),
    .rdat  (head_dat),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  assign m_valid = !empty;
  assign m_data  = head_dat[7:0];
  assign m_perr  = head_dat[8];
  assign m_ferr  = head_dat[9];

  always_comb begin
    level_nxt = fifo_level;
    if (push_en && !pop_en)      level_nxt = fifo_level + LW'(1);
    else if (pop_en && !push_en) level_nxt = fifo_level - LW'(1);
  end

  // FSM: DRAIN/OFF decisions look at the level after this cycle's traffic.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_OFF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:   if (rx_enable) state_nxt = ST_RUN;
      ST_RUN:   if (!rx_enable) state_nxt = (level_nxt != '0) ? ST_DRAIN : ST_OFF;
      ST_DRAIN: begin
        if (rx_enable)             state_nxt = ST_RUN;
        else if (level_nxt == '0)  state_nxt = ST_OFF;
      end
      default:  state_nxt = ST_OFF;
    endcase
  end

  // Idle timer: counts only while data sits untouched; saturates so the
  // interrupt fires once per idle period even if cleared while still idle.
  assign idle_clr = push_en | pop_en | empty;
  assign to_hit   = !idle_clr && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             idle_cnt <= '0;
    else if (idle_clr)                      idle_cnt <= '0;
    else if (idle_cnt != CW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + CW'(1);
  end

  // Sticky flags: a same-cycle set beats clr_status.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun     <= 1'b0;
      err_seen    <= 1'b0;
      timeout_irq <= 1'b0;
    end else begin
      if (ovr_set)         overrun <= 1'b1;
      else if (clr_status) overrun <= 1'b0;
      if (err_set)         err_seen <= 1'b1;
      else if (clr_status) err_seen <= 1'b0;
      if (to_hit)          timeout_irq <= 1'b1;
      else if (clr_status) timeout_irq <= 1'b0;
    end
  end
endmodule
